ex_mem: RTL and testbench

//  Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.

---
 rtl/ex_mem_pkg.sv | 49 ++++
 rtl/ex_mem_if.sv | 42 ++++
 rtl/ex_mem_perf.sv | 22 ++
 rtl/ex_mem.sv | 113 +++++++++++
 tb/tb_ex_mem.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register slice.
package ex_mem_pkg;

  localparam int REG_W      = 32;
  localparam int REGADDR_W  = 5;
  localparam int ALUOP_W    = 8;
  localparam int DREG_W     = 64;
  localparam int STALL_EX   = 3;
  localparam int STALL_MEM  = 4;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'h00;

  // Multi-cycle MADD/MSUB step, fed back to EX through cnt_o
  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_STEP1 = 2'd1,
    MC_STEP2 = 2'd2
  } mc_step_e;

  // Register update chosen on each edge (reset is handled in the flop stage)
  typedef enum logic [1:0] {
    UPD_FLUSH,
    UPD_BUBBLE,
    UPD_HOLD,
    UPD_ADVANCE
  } upd_e;

  typedef struct packed {
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [REG_W-1:0]     wdata;
    logic [REG_W-1:0]     hi;
    logic [REG_W-1:0]     lo;
    logic                 whilo;
    logic [ALUOP_W-1:0]   aluop;
    logic [REG_W-1:0]     mem_addr;
    logic [REG_W-1:0]     reg2;
  } mem_bus_t;

  // A step value of 3 is never legal; fold it back to IDLE
  function automatic mc_step_e legal_step(input logic [1:0] c);
    case (c)
      2'd1:    return MC_STEP1;
      2'd2:    return MC_STEP2;
      default: return MC_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX <-> MEM data bus: EX results in, registered MEM values and multi-cycle feedback out.
interface ex_mem_if #(parameter int CNT_W = 2);

  logic [4:0]       ex_wd;
  logic             ex_wreg;
  logic [31:0]      ex_wdata;
  logic [31:0]      ex_hi;
  logic [31:0]      ex_lo;
  logic             ex_whilo;
  logic [7:0]       ex_aluop;
  logic [31:0]      ex_mem_addr;
  logic [31:0]      ex_reg2;
  logic [63:0]      hilo_i;
  logic [CNT_W-1:0] cnt_i;

  logic [4:0]       mem_wd;
  logic             mem_wreg;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_hi;
  logic [31:0]      mem_lo;
  logic             mem_whilo;
  logic [7:0]       mem_aluop;
  logic [31:0]      mem_mem_addr;
  logic [31:0]      mem_reg2;
  logic [63:0]      hilo_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
           ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
           ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

endinterface

// File: rtl/ex_mem_perf.sv
// Bubble/hold event counters for the EX/MEM register (built only with EX_MEM_PERF_CNT_EN).
module ex_mem_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        hold,
  output logic [31:0] bubble_cnt,
  output logic [31:0] hold_cnt
);

  // Cleared by reset only; a flush leaves the counts intact
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (hold)   hold_cnt   <= hold_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/flush handling and MADD/MSUB partial-product feedback.
// Optional counters: define EX_MEM_PERF_CNT_EN to add bubble_cnt/hold_cnt.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_if.slave            bus
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        hold_cnt
`endif
);

  mem_bus_t         ex_bus, mem_q, mem_d;
  logic [DREG_W-1:0] hilo_q, hilo_d;
  mc_step_e         cnt_q, cnt_d;
  upd_e             upd;
  logic [CNT_W-1:0] cnt_in;
  logic             unused_stall;

  assign cnt_in       = bus.cnt_i;
  assign unused_stall = ^{stall[2:0], stall[STALL_W-1:5]};

  assign ex_bus = '{
    wd:       bus.ex_wd,
    wreg:     bus.ex_wreg,
    wdata:    bus.ex_wdata,
    hi:       bus.ex_hi,
    lo:       bus.ex_lo,
    whilo:    bus.ex_whilo,
    aluop:    bus.ex_aluop,
    mem_addr: bus.ex_mem_addr,
    reg2:     bus.ex_reg2
  };

  // EX running with MEM stalled is illegal from ctrl and falls into hold
  always_comb begin
    upd    = UPD_ADVANCE;
    mem_d  = mem_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    if (flush)
      upd = UPD_FLUSH;
    else if (stall[STALL_EX] && !stall[STALL_MEM])
      upd = UPD_BUBBLE;
    else if (stall[STALL_MEM])
      upd = UPD_HOLD;

    case (upd)
      UPD_FLUSH: begin
        mem_d  = '0;
        hilo_d = '0;
        cnt_d  = MC_IDLE;
      end
      UPD_BUBBLE: begin
        mem_d       = '0;
        mem_d.aluop = EXE_NOP_OP;
        hilo_d      = bus.hilo_i;
        cnt_d       = legal_step(cnt_in);
      end
      UPD_HOLD: begin
      end
      default: begin
        mem_d  = ex_bus;
        hilo_d = '0;
        cnt_d  = MC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      hilo_q <= '0;
      cnt_q  <= MC_IDLE;
    end else begin
      mem_q  <= mem_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.mem_wd       = mem_q.wd;
  assign bus.mem_wreg     = mem_q.wreg;
  assign bus.mem_wdata    = mem_q.wdata;
  assign bus.mem_hi       = mem_q.hi;
  assign bus.mem_lo       = mem_q.lo;
  assign bus.mem_whilo    = mem_q.whilo;
  assign bus.mem_aluop    = mem_q.aluop;
  assign bus.mem_mem_addr = mem_q.mem_addr;
  assign bus.mem_reg2     = mem_q.reg2;
  assign bus.hilo_o       = hilo_q;
  assign bus.cnt_o        = cnt_q;

`ifdef EX_MEM_PERF_CNT_EN
  ex_mem_perf u_perf (
    .clk        (clk),
    .rst        (rst),
    .bubble     (upd == UPD_BUBBLE),
    .hold       (upd == UPD_HOLD),
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
  );
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed vector bench for ex_mem: reset, advance, bubble, hold, flush and MADD feedback.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
  } pk_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    int unsigned in_pk;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    int unsigned exp_pk;
    logic [63:0] exp_hilo;
    logic [1:0]  exp_cnt;
  } vec_t;

  localparam int unsigned Z = 0, A = 1, B = 2, C = 3;
  localparam logic [5:0] S_RUN = 6'b000000, S_BUB = 6'b001111,
                         S_HLD = 6'b011111, S_BAD = 6'b010000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  int         checks = 0;
  int         errors = 0;
  pk_t        packs [4];
  vec_t       vecs [20];

  ex_mem_if #(.CNT_W(2)) bus ();

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] bubble_cnt, hold_cnt;
`endif

  ex_mem #(.STALL_W(6), .CNT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
`ifdef EX_MEM_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pk_t p;
    p = packs[v.in_pk];
    rst = v.rst;
    flush = v.flush;
    stall = v.stall;
    bus.ex_wd = p.wd;
    bus.ex_wreg = p.wreg;
    bus.ex_wdata = p.wdata;
    bus.ex_hi = p.hi;
    bus.ex_lo = p.lo;
    bus.ex_whilo = p.whilo;
    bus.ex_aluop = p.aluop;
    bus.ex_mem_addr = p.addr;
    bus.ex_reg2 = p.reg2;
    bus.hilo_i = v.hilo_i;
    bus.cnt_i = v.cnt_i;
  endtask

  function automatic vec_t mkv(input logic r, input logic f, input logic [5:0] s,
                               input int unsigned ip, input logic [63:0] hi,
                               input logic [1:0] ci, input int unsigned ep,
                               input logic [63:0] eh, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.in_pk = ip; v.hilo_i = hi; v.cnt_i = ci;
    v.exp_pk = ep; v.exp_hilo = eh; v.exp_cnt = ec;
    return v;
  endfunction

  // Apply one edge with simple inputs and sample #1 after it
  task automatic edge_with(input logic r, input logic f, input logic [5:0] s);
    drive(mkv(r, f, s, A, 64'h0, 2'd1, Z, 64'h0, 2'd0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    packs[Z] = '0;
    packs[A] = '{wd: 5'd3, wreg: 1'b1, wdata: 32'hDEADBEEF, hi: 32'h11, lo: 32'h22,
                 whilo: 1'b0, aluop: 8'h23, addr: 32'h1000, reg2: 32'h55};
    packs[B] = '{wd: 5'd31, wreg: 1'b1, wdata: 32'hCAFEF00D, hi: 32'hA5A5A5A5,
                 lo: 32'h5A5A5A5A, whilo: 1'b1, aluop: 8'h2B, addr: 32'hFFFF_FFFC,
                 reg2: 32'h1234_5678};
    packs[C] = '{wd: 5'd0, wreg: 1'b0, wdata: 32'h0, hi: 32'h5, lo: 32'h7,
                 whilo: 1'b1, aluop: 8'h18, addr: 32'h0, reg2: 32'h0};

    //            rst   flush stall  in hilo_i                  cnt  exp hilo                     cnt
    vecs[0]  = mkv(1'b1, 1'b0, S_RUN, A, 64'hFFFF,               2'd1, Z, 64'h0,                   2'd0);
    vecs[1]  = mkv(1'b1, 1'b0, S_RUN, A, 64'hFFFF,               2'd1, Z, 64'h0,                   2'd0);
    vecs[2]  = mkv(1'b0, 1'b0, S_RUN, A, 64'h123,                2'd1, A, 64'h0,                   2'd0);
    vecs[3]  = mkv(1'b0, 1'b0, S_BUB, B, 64'h1_0000_0002,        2'd1, Z, 64'h1_0000_0002,         2'd1);
    vecs[4]  = mkv(1'b0, 1'b0, S_RUN, B, 64'h55,                 2'd2, B, 64'h0,                   2'd0);
    vecs[5]  = mkv(1'b0, 1'b0, S_HLD, A, 64'h7,                  2'd2, B, 64'h0,                   2'd0);
    vecs[6]  = mkv(1'b0, 1'b0, S_HLD, A, 64'h7,                  2'd2, B, 64'h0,                   2'd0);
    vecs[7]  = mkv(1'b0, 1'b0, S_HLD, A, 64'h7,                  2'd2, B, 64'h0,                   2'd0);
    vecs[8]  = mkv(1'b0, 1'b0, S_RUN, A, 64'h0,                  2'd0, A, 64'h0,                   2'd0);
    vecs[9]  = mkv(1'b0, 1'b0, S_BUB, A, 64'hABCD,               2'd3, Z, 64'hABCD,                2'd0);
    vecs[10] = mkv(1'b0, 1'b0, S_BUB, A, 64'h99,                 2'd2, Z, 64'h99,                  2'd2);
    vecs[11] = mkv(1'b0, 1'b0, S_HLD, B, 64'h77,                 2'd1, Z, 64'h99,                  2'd2);
    vecs[12] = mkv(1'b0, 1'b0, S_BAD, B, 64'h77,                 2'd1, Z, 64'h99,                  2'd2);
    vecs[13] = mkv(1'b0, 1'b1, S_HLD, A, 64'h77,                 2'd1, Z, 64'h0,                   2'd0);
    vecs[14] = mkv(1'b0, 1'b0, S_BUB, C, 64'h0000_0003_0000_0004, 2'd1, Z, 64'h0000_0003_0000_0004, 2'd1);
    vecs[15] = mkv(1'b0, 1'b0, S_RUN, C, 64'h0000_0003_0000_0004, 2'd2, C, 64'h0,                   2'd0);
    vecs[16] = mkv(1'b0, 1'b0, S_BUB, A, 64'h42,                 2'd1, Z, 64'h42,                  2'd1);
    vecs[17] = mkv(1'b0, 1'b1, S_RUN, A, 64'h42,                 2'd1, Z, 64'h0,                   2'd0);
    vecs[18] = mkv(1'b0, 1'b0, S_BUB, B, 64'h42,                 2'd1, Z, 64'h42,                  2'd1);
    vecs[19] = mkv(1'b1, 1'b0, S_RUN, A, 64'h42,                 2'd1, Z, 64'h0,                   2'd0);

    drive(vecs[0]);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      pk_t e;
      drive(vecs[i]);
      @(posedge clk);
      #1;
      e = packs[vecs[i].exp_pk];
      chk($sformatf("v%0d.wd", i),    {59'd0, bus.mem_wd},        {59'd0, e.wd});
      chk($sformatf("v%0d.wreg", i),  {63'd0, bus.mem_wreg},      {63'd0, e.wreg});
      chk($sformatf("v%0d.wdata", i), {32'd0, bus.mem_wdata},     {32'd0, e.wdata});
      chk($sformatf("v%0d.hi", i),    {32'd0, bus.mem_hi},        {32'd0, e.hi});
      chk($sformatf("v%0d.lo", i),    {32'd0, bus.mem_lo},        {32'd0, e.lo});
      chk($sformatf("v%0d.whilo", i), {63'd0, bus.mem_whilo},     {63'd0, e.whilo});
      chk($sformatf("v%0d.aluop", i), {56'd0, bus.mem_aluop},     {56'd0, e.aluop});
      chk($sformatf("v%0d.addr", i),  {32'd0, bus.mem_mem_addr},  {32'd0, e.addr});
      chk($sformatf("v%0d.reg2", i),  {32'd0, bus.mem_reg2},      {32'd0, e.reg2});
      chk($sformatf("v%0d.hilo", i),  bus.hilo_o,                 vecs[i].exp_hilo);
      chk($sformatf("v%0d.cnt", i),   {62'd0, bus.cnt_o},         {62'd0, vecs[i].exp_cnt});
    end

`ifdef EX_MEM_PERF_CNT_EN
    edge_with(1'b1, 1'b0, S_RUN);
    chk("perf.rst_bubble", {32'd0, bubble_cnt}, 64'd0);
    chk("perf.rst_hold",   {32'd0, hold_cnt},   64'd0);
    for (int i = 0; i < 4; i++) edge_with(1'b0, 1'b0, S_BUB);
    edge_with(1'b0, 1'b0, S_HLD);
    edge_with(1'b0, 1'b0, S_BAD);
    chk("perf.bubble4", {32'd0, bubble_cnt}, 64'd4);
    chk("perf.hold2",   {32'd0, hold_cnt},   64'd2);
    edge_with(1'b0, 1'b1, S_HLD);
    chk("perf.flush_bubble", {32'd0, bubble_cnt}, 64'd4);
    chk("perf.flush_hold",   {32'd0, hold_cnt},   64'd2);
    edge_with(1'b0, 1'b0, S_RUN);
    chk("perf.adv_bubble", {32'd0, bubble_cnt}, 64'd4);
    edge_with(1'b1, 1'b0, S_BUB);
    chk("perf.clr_bubble", {32'd0, bubble_cnt}, 64'd0);
    chk("perf.clr_hold",   {32'd0, hold_cnt},   64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
